// File: rtl/lobster_pkg.sv
// Shared types and constants for the lobster fetch front end and its decoder.
package lobster_pkg;

  localparam int          DEF_ADDR_WIDTH = 36;
  localparam logic [35:0] DEF_RESET_PC   = 36'hF800;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  // Instruction prefix bytes, consumed by the decoder.
  localparam logic [7:0] PREFIX_MICRO = 8'hF0;
  localparam logic [7:0] PREFIX_LONG  = 8'hF1;
  localparam logic [7:0] PREFIX_REP   = 8'hF2;

  // One prefetch entry: the fetched word together with its PC.
  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0] pc;
    logic [63:0]               data;
  } fetch_entry_t;

endpackage

// File: rtl/lobster_fifo.sv
// Shift-register FIFO: entry 0 is always the head, so the head word and the
// valid/level outputs come straight from flops.
module lobster_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(DEPTH);
  localparam logic [LW-1:0] ONE  = LW'(1'b1);
  localparam logic [LW-1:0] ZERO = {LW{1'b0}};

  logic [WIDTH-1:0] q [DEPTH];
  logic             pop_ok;
  logic [LW-1:0]    level_nx;
  logic [LW-1:0]    wr_idx;

  // Next occupancy and the slot a push lands in after any same-cycle pop.
  always_comb begin
    pop_ok   = pop & (level != ZERO);
    wr_idx   = level - (pop_ok ? ONE : ZERO);
    level_nx = flush ? ZERO : (level + (push ? ONE : ZERO) - (pop_ok ? ONE : ZERO));
  end

  // Storage: shift toward the head on pop, write behind the last live entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= {WIDTH{1'b0}};
    end else if (!flush) begin
      if (pop_ok) begin
        for (int i = 0; i < DEPTH - 1; i++) q[i] <= q[i+1];
      end
      if (push) q[wr_idx[IW-1:0]] <= din;
    end
  end

  // Occupancy and head-valid flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level <= ZERO;
      valid <= 1'b0;
    end else begin
      level <= level_nx;
      valid <= (level_nx != ZERO);
    end
  end

  assign dout = q[0];

endmodule

// File: rtl/lobster_fifo_chk.sv
// Simulation checker for the prefetch FIFO: issue-time reservation must
// guarantee that a push never lands on a full FIFO without a same-cycle pop.
module lobster_fifo_chk #(
  parameter int DEPTH = 4
) (
  input logic                       clk,
  input logic                       rst,
  input logic                       push,
  input logic                       pop,
  input logic                       flush,
  input logic [$clog2(DEPTH):0]     level
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    (push && !flush && !pop) |-> (level < DEPTH_L))
    else $error("lobster_fifo_chk: push into a full prefetch FIFO");

endmodule

// File: rtl/lobster_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues one outstanding 64-bit
// SRAM read at a time and buffers returned words with their PCs for the decoder.
module lobster_fetch
  import lobster_pkg::*;
#(
  parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEF_RESET_PC),
  parameter int                    FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fetch_en,
  input  logic                          redir_valid,
  input  logic [ADDR_WIDTH-1:0]         redir_pc,
  output logic                          mem_ce,
  output logic                          mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  input  logic [63:0]                   mem_data,
  input  logic                          mem_rdy,
  output logic                          inst_valid,
  output logic [63:0]                   inst_data,
  output logic [ADDR_WIDTH-1:0]         inst_pc,
  input  logic                          inst_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = ADDR_WIDTH + 64;
  localparam logic [LW-1:0]         DEPTH_L    = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0]         ONE        = LW'(1'b1);
  localparam logic [LW-1:0]         ZERO       = {LW{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] STEP       = {{(ADDR_WIDTH-4){1'b0}}, 4'd8};
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-3){1'b1}}, 3'b000};

  fetch_state_t          state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] target;
  logic                  push;
  logic                  pop;
  logic                  flush;
  logic [LW-1:0]         post_level;
  logic [EW-1:0]         head;

  // Handshake strobes; a redirect overrides push and pop in its cycle.
  always_comb begin
    flush      = redir_valid;
    pop        = inst_valid & inst_ready & ~redir_valid;
    push       = (state == REQ) & mem_rdy & ~redir_valid;
    pc_inc     = pc + STEP;
    target     = redir_pc & ALIGN_MASK;
    post_level = fifo_level + (push ? ONE : ZERO) - (pop ? ONE : ZERO);
  end

  // Fetch sequencer: state, PC and the registered SRAM command.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      mem_addr <= RESET_PC;
      mem_ce   <= 1'b0;
      mem_we   <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          pc <= redir_valid ? target : pc;
          // A redirect empties the FIFO, so space is available whatever the level.
          if (fetch_en && (redir_valid || fifo_level < DEPTH_L)) begin
            state    <= REQ;
            mem_ce   <= 1'b1;
            mem_addr <= redir_valid ? target : pc;
          end else begin
            state  <= IDLE;
            mem_ce <= 1'b0;
          end
        end
        REQ: begin
          if (redir_valid) begin
            pc <= target;
            if (!mem_rdy) begin
              state  <= DROP;        // keep the stale address until it completes
              mem_ce <= 1'b1;
            end else if (fetch_en) begin
              state    <= REQ;
              mem_ce   <= 1'b1;
              mem_addr <= target;
            end else begin
              state  <= IDLE;
              mem_ce <= 1'b0;
            end
          end else if (mem_rdy) begin
            pc <= pc_inc;
            if (fetch_en && post_level < DEPTH_L) begin
              state    <= REQ;
              mem_ce   <= 1'b1;
              mem_addr <= pc_inc;
            end else begin
              state  <= IDLE;
              mem_ce <= 1'b0;
            end
          end else begin
            state  <= REQ;
            mem_ce <= 1'b1;
          end
        end
        DROP: begin
          pc <= redir_valid ? target : pc;
          if (mem_rdy && fetch_en) begin
            state    <= REQ;
            mem_ce   <= 1'b1;
            mem_addr <= redir_valid ? target : pc;
          end else if (mem_rdy) begin
            state  <= IDLE;
            mem_ce <= 1'b0;
          end else begin
            state  <= DROP;
            mem_ce <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          mem_ce <= 1'b0;
        end
      endcase
    end
  end

  lobster_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   ({mem_addr, mem_data}),
    .dout  (head),
    .valid (inst_valid),
    .level (fifo_level)
  );

  lobster_fifo_chk #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo_chk (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .level (fifo_level)
  );

  assign inst_pc   = head[EW-1:64];
  assign inst_data = head[63:0];

endmodule
